square_tone_gen: RTL and testbench

Switch-selected square-wave tone source for the SoundStuff audio path. A 4-bit user switch value is synchronized and mapped through a fixed lookup table to an 8-bit half-period, the frequency control word. An 8-bit sample counter then produces a full-scale square wave at that rate. The output feeds the downstream sample/DAC stage and runs one sample per clock.

---
 rtl/tone_pkg.sv | 21 ++
 rtl/switch_freq_map.sv | 30 +++
 rtl/square_tone_gen.sv | 48 ++++
 tb/tb_square_tone_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared constants for the switch-selected square tone source.
//   WIDTH       : sample / frequency-control width
//   SW_W        : user switch width
//   HALF_PERIOD : switch index -> half-period in clocks (0 = mute)
//   MUTE        : half-period value that silences the generator
package tone_pkg;

  localparam int WIDTH = 8;
  localparam int SW_W  = 4;
  localparam int MUTE  = 0;

  typedef logic [SW_W-1:0]  sw_t;
  typedef logic [WIDTH-1:0] hp_t;

  // Packed, entry 15 first so that HALF_PERIOD[i] is table entry i.
  localparam hp_t [15:0] HALF_PERIOD = {
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd28, 8'd24, 8'd20,
    8'd16, 8'd14, 8'd12, 8'd10, 8'd8,  8'd6,  8'd4,  8'd0
  };

endpackage

// File: rtl/switch_freq_map.sv
// switch_freq_map: brings the asynchronous user switch into the clk domain
// and registers its half-period from the lookup table.
//   clk, rst_n        : clock, async active-low reset
//   switch            : raw user tone select (asynchronous)
//   frequency_control : registered half-period, 3 edges after switch
module switch_freq_map #(
  parameter int WIDTH = tone_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [tone_pkg::SW_W-1:0] switch,
  output logic [WIDTH-1:0]         frequency_control
);
  import tone_pkg::*;

  sw_t sw_s1, sw_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1             <= '0;
      sw_s2             <= '0;
      frequency_control <= '0;
    end else begin
      sw_s1             <= switch;
      sw_s2             <= sw_s1;
      frequency_control <= WIDTH'(HALF_PERIOD[sw_s2]);
    end
  end

endmodule

// File: rtl/square_tone_gen.sv
// square_tone_gen: switch-selected full-scale square wave, one sample/clock.
//   clk, rst_n        : clock, async active-low reset
//   switch            : user tone select (asynchronous)
//   frequency_control : registered half-period in clocks, 0 = mute
//   square_out        : 0 or AMPLITUDE, period 2*frequency_control
module square_tone_gen #(
  parameter int               WIDTH     = tone_pkg::WIDTH,
  parameter logic [WIDTH-1:0] AMPLITUDE = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [tone_pkg::SW_W-1:0] switch,
  output logic [WIDTH-1:0]          frequency_control,
  output logic [WIDTH-1:0]          square_out
);
  import tone_pkg::*;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MUTE_FC = WIDTH'(MUTE);

  logic [WIDTH-1:0] count;

  switch_freq_map #(.WIDTH(WIDTH)) u_map (
    .clk               (clk),
    .rst_n             (rst_n),
    .switch            (switch),
    .frequency_control (frequency_control)
  );

  // >= rather than == so a half-period that shrinks below the running count
  // toggles on the next edge; count and level are kept across tone changes
  // for phase continuity. Count never exceeds the largest table entry - 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      square_out <= '0;
    end else if (frequency_control == MUTE_FC) begin
      count      <= '0;
      square_out <= '0;
    end else if (count >= frequency_control - ONE) begin
      count      <= '0;
      square_out <= (square_out == '0) ? AMPLITUDE : '0;
    end else begin
      count      <= count + ONE;
    end
  end

endmodule

// File: tb/tb_square_tone_gen.sv
module tb_square_tone_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw0, sw1;
  logic [7:0] fc0, sq0, fc1, sq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  square_tone_gen dut0 (
    .clk(clk), .rst_n(rst_n), .switch(sw0),
    .frequency_control(fc0), .square_out(sq0)
  );

  square_tone_gen #(.WIDTH(8), .AMPLITUDE(8'h80)) dut1 (
    .clk(clk), .rst_n(rst_n), .switch(sw1),
    .frequency_control(fc1), .square_out(sq1)
  );

  // ---------------- reference model ----------------
  // Tone table straight from the spec; fc appears 3 edges after the switch.
  int tbl [16] = '{0, 4, 6, 8, 10, 12, 14, 16, 20, 24, 28, 32, 40, 48, 56, 64};

  typedef struct packed { logic [7:0] fc; logic [7:0] sq; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  int   hist  [2][2];   // switch seen two edges ago / one edge ago
  int   m_fc  [2];      // half-period in force before this edge
  int   spent [2];      // edges already spent at the current level
  logic [7:0] m_lvl [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      hist[i][0] = 0; hist[i][1] = 0;
      m_fc[i] = 0; spent[i] = 0; m_lvl[i] = 8'h00;
    end
    sb0.delete(); sb1.delete();
  endtask

  task automatic model_edge(input int i, input int sw, input logic [7:0] amp);
    exp_t e;
    if (m_fc[i] == 0) begin
      spent[i] = 0; m_lvl[i] = 8'h00;
    end else if (spent[i] + 1 >= m_fc[i]) begin
      // this edge completes the half-period (or it already overran a shrink)
      spent[i] = 0;
      m_lvl[i] = (m_lvl[i] == 8'h00) ? amp : 8'h00;
    end else begin
      spent[i]++;
    end
    m_fc[i]    = tbl[hist[i][0]];
    hist[i][0] = hist[i][1];
    hist[i][1] = sw;
    e.fc = 8'(m_fc[i]);
    e.sq = m_lvl[i];
    if (i == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  initial model_clear();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else begin
      model_edge(0, int'(sw0), 8'hFF);
      model_edge(1, int'(sw1), 8'h80);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        checks++;
        if (fc0 !== e.fc) begin
          errors++;
          $display("FAIL fc0 t=%0t got %0d want %0d", $time, fc0, e.fc);
        end
        checks++;
        if (sq0 !== e.sq) begin
          errors++;
          $display("FAIL sq0 t=%0t got %h want %h", $time, sq0, e.sq);
        end
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        checks++;
        if (fc1 !== e.fc || sq1 !== e.sq) begin
          errors++;
          $display("FAIL amp80 t=%0t got fc=%0d sq=%h want fc=%0d sq=%h",
                   $time, fc1, sq1, e.fc, e.sq);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (fc0 !== 8'h00 || sq0 !== 8'h00 || fc1 !== 8'h00 || sq1 !== 8'h00) begin
      errors++;
      $display("FAIL %s got fc0=%h sq0=%h fc1=%h sq1=%h want all 00",
               tag, fc0, sq0, fc1, sq1);
    end
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic async_reset(input int hold);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    wait_clks(hold);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
  endtask

  task automatic wait_high(input int budget);
    int n = 0;
    while (sq0 !== 8'hFF && n < budget) begin
      @(negedge clk); n++;
    end
    #2;
    checks++;
    if (sq0 !== 8'hFF) begin
      errors++;
      $display("FAIL wait_high got %h want ff within %0d clks", sq0, budget);
    end
  endtask

  initial begin
    int steps [8] = '{1, 2, 3, 4, 5, 10, 15, 0};
    rst_n = 1'b0;
    sw0 = 4'd1;
    sw1 = 4'd3;
    #13 check_reset_outputs("reset_initial");
    wait_clks(3);
    check_reset_outputs("reset_held_sw1");
    rst_n = 1'b1;

    // switch=1 from reset, period 8
    wait_clks(30);

    // step sequence
    foreach (steps[k]) begin
      sw0 = 4'(steps[k]);
      wait_clks(25);
    end

    // shrink mid-period: 64-clock half-period, count around 40, then 1
    sw0 = 4'd15;
    wait_clks(3 + 40);
    sw0 = 4'd1;
    wait_clks(30);

    // mute while high, hold, then restart at 6
    sw0 = 4'd2;
    wait_clks(5);
    wait_high(100);
    sw0 = 4'd0;
    wait_clks(55);
    sw0 = 4'd2;
    wait_clks(30);

    // reset mid-run
    async_reset(4);
    wait_clks(40);

    // randomized segments with occasional resets
    for (int s = 0; s < 40; s++) begin
      sw0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) sw1 = 4'($urandom_range(0, 15));
      wait_clks($urandom_range(1, 90));
      if ($urandom_range(0, 9) == 0) async_reset($urandom_range(1, 5));
    end

    wait_clks(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
